// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote stage: ballot collector and vote decoder.
//   N_VOTERS  voters per round (slots A..E)
//   CAND_W    one-hot candidate code width
//   ID_W      voter index width
//   CAND_0..2 the three legal candidate codes
//   state_t   collector state (COLLECT, PRESENT)
// -----------------------------------------------------------------------------
package vote_pkg;

   localparam int N_VOTERS = 5;
   localparam int CAND_W   = 3;
   localparam int ID_W     = 3;
   localparam int CNT_W    = 8;

   localparam logic [CAND_W-1:0] CAND_0    = 3'b001;
   localparam logic [CAND_W-1:0] CAND_1    = 3'b010;
   localparam logic [CAND_W-1:0] CAND_2    = 3'b100;
   localparam logic [CAND_W-1:0] CAND_NONE = 3'b000;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // A ballot is legal only when it is exactly one of the candidate codes.
   function automatic logic is_candidate(input logic [CAND_W-1:0] code);
      return (code == CAND_0) || (code == CAND_1) || (code == CAND_2);
   endfunction

   // One-hot select of a voter slot; ids at or above N_VOTERS shift out to 0.
   function automatic logic [N_VOTERS-1:0] voter_sel(input logic [ID_W-1:0] id);
      logic [N_VOTERS-1:0] one;
      one = {{(N_VOTERS-1){1'b0}}, 1'b1};
      return one << id;
   endfunction

endpackage

// File: rtl/ballot_check.sv
// -----------------------------------------------------------------------------
// ballot_check
// Combinational legality check for one offered ballot.
//   ballot     in  candidate code, must be exactly one-hot
//   voter_id   in  voter index, must be below N_VOTERS
//   voted      in  per-voter flags of ballots already stored this round
//   accept_ok  out ballot may be stored
// -----------------------------------------------------------------------------
module ballot_check
   import vote_pkg::*;
(
   input  logic [CAND_W-1:0]   ballot,
   input  logic [ID_W-1:0]     voter_id,
   input  logic [N_VOTERS-1:0] voted,
   output logic                accept_ok
);

   logic                code_ok;
   logic                id_ok;
   logic                repeat_vote;
   logic [N_VOTERS-1:0] sel;

   always_comb begin
      sel         = voter_sel(voter_id);
      code_ok     = is_candidate(ballot);
      id_ok       = (voter_id < ID_W'(N_VOTERS));
      // Out-of-range ids give an all-zero select, so this term is 0 for them
      // and id_ok alone refuses the ballot.
      repeat_vote = |(voted & sel);
      accept_ok   = code_ok && id_ok && !repeat_vote;
   end

endmodule

// File: rtl/ballot_collector.sv
// -----------------------------------------------------------------------------
// ballot_collector
// Front end of the vote stage. Accepts ballots over valid/ready, checks each
// one, stores it in its voter's slot, and presents all five slots on A..E with
// round_valid once every voter has cast a legal ballot. The round is held until
// round_ack (counted in round_cnt) or discarded by round_abort.
//   clk           in  clock, rising edge
//   rst           in  synchronous active-high reset
//   ballot_valid  in  ballot offered this cycle
//   ballot        in  one-hot candidate code
//   voter_id      in  voter index, 0..4 -> A..E
//   ballot_ready  out collector accepts ballots this cycle
//   round_ack     in  consumer has taken the presented round
//   round_abort   in  discard the partial or presented round
//   A..E          out stored ballots, 000 = empty slot
//   round_valid   out all five slots filled and frozen
//   reject        out one-cycle pulse: previous offered ballot was refused
//   round_cnt     out acknowledged rounds, wraps 255 -> 0
// -----------------------------------------------------------------------------
module ballot_collector
   import vote_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ballot_valid,
   input  logic [CAND_W-1:0] ballot,
   input  logic [ID_W-1:0]   voter_id,
   output logic              ballot_ready,
   input  logic              round_ack,
   input  logic              round_abort,
   output logic [CAND_W-1:0] A,
   output logic [CAND_W-1:0] B,
   output logic [CAND_W-1:0] C,
   output logic [CAND_W-1:0] D,
   output logic [CAND_W-1:0] E,
   output logic              round_valid,
   output logic              reject,
   output logic [CNT_W-1:0]  round_cnt
);

   state_t              state_q;
   state_t              state_d;
   logic [CAND_W-1:0]   slot_q [N_VOTERS];
   logic [N_VOTERS-1:0] voted_q;
   logic [N_VOTERS-1:0] voted_next;
   logic [N_VOTERS-1:0] sel;
   logic [CNT_W-1:0]    round_cnt_q;
   logic                reject_q;
   logic                reject_d;
   logic                accept_ok;
   logic                offered;
   logic                accept;
   logic                clear_round;
   logic                count_round;

   ballot_check u_check (
      .ballot    (ballot),
      .voter_id  (voter_id),
      .voted     (voted_q),
      .accept_ok (accept_ok)
   );

   // Ready comes from the state register (and reset) only, so upstream never
   // sees a combinational path from ballot_valid or the ballot contents.
   assign ballot_ready = (state_q == COLLECT) && !rst;

   always_comb begin
      sel         = voter_sel(voter_id);
      voted_next  = voted_q | sel;
      offered     = ballot_valid && ballot_ready;
      // Abort outranks acceptance: a ballot offered alongside an abort is
      // dropped silently, without a reject pulse.
      accept      = offered && accept_ok && !round_abort;
      reject_d    = offered && !accept_ok && !round_abort;
   end

   // Next-state and round control.
   always_comb begin
      state_d     = state_q;
      clear_round = 1'b0;
      count_round = 1'b0;
      case (state_q)
         COLLECT: begin
            if (round_abort) begin
               clear_round = 1'b1;
            end else if (accept && (&voted_next)) begin
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (round_abort) begin
               clear_round = 1'b1;
               state_d     = COLLECT;
            end else if (round_ack) begin
               clear_round = 1'b1;
               count_round = 1'b1;
               state_d     = COLLECT;
            end
         end
         default: begin
            clear_round = 1'b1;
            state_d     = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         voted_q     <= '0;
         reject_q    <= 1'b0;
         round_cnt_q <= '0;
         for (int i = 0; i < N_VOTERS; i++) begin
            slot_q[i] <= CAND_NONE;
         end
      end else begin
         state_q  <= state_d;
         reject_q <= reject_d;
         if (clear_round) begin
            voted_q <= '0;
            for (int i = 0; i < N_VOTERS; i++) begin
               slot_q[i] <= CAND_NONE;
            end
         end else if (accept) begin
            voted_q <= voted_next;
            for (int i = 0; i < N_VOTERS; i++) begin
               if (sel[i]) begin
                  slot_q[i] <= ballot;
               end
            end
         end
         if (count_round) begin
            round_cnt_q <= round_cnt_q + 1'b1;
         end
      end
   end

   assign A           = slot_q[0];
   assign B           = slot_q[1];
   assign C           = slot_q[2];
   assign D           = slot_q[3];
   assign E           = slot_q[4];
   assign round_valid = (state_q == PRESENT);
   assign reject      = reject_q;
   assign round_cnt   = round_cnt_q;

endmodule

// File: tb/tb_ballot_collector.sv
// -----------------------------------------------------------------------------
// tb_ballot_collector
// Directed bench for ballot_collector: full round, illegal ballots, duplicate
// voter, backpressure in PRESENT, abort, mid-round reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_ballot_collector;

   logic       clk;
   logic       rst;
   logic       ballot_valid;
   logic [2:0] ballot;
   logic [2:0] voter_id;
   logic       ballot_ready;
   logic       round_ack;
   logic       round_abort;
   logic [2:0] A, B, C, D, E;
   logic       round_valid;
   logic       reject;
   logic [7:0] round_cnt;

   int checks;
   int failures;

   ballot_collector dut (
      .clk          (clk),
      .rst          (rst),
      .ballot_valid (ballot_valid),
      .ballot       (ballot),
      .voter_id     (voter_id),
      .ballot_ready (ballot_ready),
      .round_ack    (round_ack),
      .round_abort  (round_abort),
      .A            (A),
      .B            (B),
      .C            (C),
      .D            (D),
      .E            (E),
      .round_valid  (round_valid),
      .reject       (reject),
      .round_cnt    (round_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference vote decoder: candidate holding a strict majority of 5, else 000.
   function automatic logic [2:0] majority(input logic [2:0] a, b, c, d, e);
      logic [2:0] v [5];
      int         n;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         for (int j = 0; j < 5; j++) begin
            if (v[j] == (3'b001 << k)) n++;
         end
         if (n >= 3) return 3'b001 << k;
      end
      return 3'b000;
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] id, input logic [2:0] b);
      ballot_valid = 1'b1;
      voter_id     = id;
      ballot       = b;
      step();
      ballot_valid = 1'b0;
   endtask

   task automatic run_round();
      for (int k = 0; k < 5; k++) offer(3'(k), 3'b001);
      round_ack = 1'b1;
      step();
      round_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (ballot_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ballot_ready); end
      checks++; if ({A, B, C, D, E} !== 15'd0) begin failures++; $display("FAIL reset_slots got=%h exp=0", {A, B, C, D, E}); end
      checks++; if (round_valid !== 1'b0) begin failures++; $display("FAIL reset_round_valid got=%b exp=0", round_valid); end
      checks++; if (reject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%b exp=0", reject); end
      checks++; if (round_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", round_cnt); end
      rst = 1'b0;
      #1;
      checks++; if (ballot_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", ballot_ready); end
   endtask

   task automatic test_full_round();
      logic [2:0] ids [5];
      logic [2:0] vals [5];
      vals[0] = 3'b001; vals[1] = 3'b001; vals[2] = 3'b010; vals[3] = 3'b100; vals[4] = 3'b001;
      for (int k = 0; k < 5; k++) ids[k] = 3'(k);
      for (int k = 0; k < 4; k++) begin
         offer(ids[k], vals[k]);
         checks++; if (round_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid k=%0d got=%b exp=0", k, round_valid); end
      end
      checks++; if (D !== 3'b100) begin failures++; $display("FAIL full_d_latency got=%b exp=100", D); end
      offer(ids[4], vals[4]);
      checks++; if (round_valid !== 1'b1) begin failures++; $display("FAIL full_round_valid got=%b exp=1", round_valid); end
      checks++; if (ballot_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ballot_ready); end
      checks++; if ({A, B, C, D, E} !== {3'b001, 3'b001, 3'b010, 3'b100, 3'b001}) begin
         failures++; $display("FAIL full_slots got=%b %b %b %b %b exp=001 001 010 100 001", A, B, C, D, E);
      end
      checks++; if (majority(A, B, C, D, E) !== 3'b001) begin failures++; $display("FAIL full_R got=%b exp=001", majority(A, B, C, D, E)); end
      step();
      checks++; if ({A, B, C, D, E} !== {3'b001, 3'b001, 3'b010, 3'b100, 3'b001}) begin failures++; $display("FAIL full_frozen got=%h", {A, B, C, D, E}); end
      round_ack = 1'b1;
      step();
      round_ack = 1'b0;
      checks++; if (round_valid !== 1'b0) begin failures++; $display("FAIL ack_round_valid got=%b exp=0", round_valid); end
      checks++; if ({A, B, C, D, E} !== 15'd0) begin failures++; $display("FAIL ack_slots got=%h exp=0", {A, B, C, D, E}); end
      checks++; if (round_cnt !== 8'd1) begin failures++; $display("FAIL ack_cnt got=%0d exp=1", round_cnt); end
      checks++; if (ballot_ready !== 1'b1) begin failures++; $display("FAIL ack_ready got=%b exp=1", ballot_ready); end
   endtask

   task automatic test_illegal();
      logic [2:0] bad_b  [4];
      logic [2:0] bad_id [4];
      bad_b[0] = 3'b000; bad_id[0] = 3'd1;
      bad_b[1] = 3'b011; bad_id[1] = 3'd1;
      bad_b[2] = 3'b111; bad_id[2] = 3'd1;
      bad_b[3] = 3'b001; bad_id[3] = 3'd6;
      offer(3'd0, 3'b010);
      checks++; if (A !== 3'b010) begin failures++; $display("FAIL ill_seed got=%b exp=010", A); end
      checks++; if (reject !== 1'b0) begin failures++; $display("FAIL ill_seed_reject got=%b exp=0", reject); end
      for (int k = 0; k < 4; k++) begin
         offer(bad_id[k], bad_b[k]);
         checks++; if (reject !== 1'b1) begin failures++; $display("FAIL ill_reject k=%0d got=%b exp=1", k, reject); end
         checks++; if ({A, B, C, D, E} !== {3'b010, 12'd0}) begin failures++; $display("FAIL ill_slots k=%0d got=%h exp=%h", k, {A, B, C, D, E}, {3'b010, 12'd0}); end
         step();
         checks++; if (reject !== 1'b0) begin failures++; $display("FAIL ill_pulse k=%0d got=%b exp=0", k, reject); end
      end
      // Voter 1 must still be free.
      offer(3'd1, 3'b100);
      checks++; if (B !== 3'b100 || reject !== 1'b0) begin failures++; $display("FAIL ill_voted B=%b reject=%b exp B=100 reject=0", B, reject); end
   endtask

   task automatic test_duplicate();
      offer(3'd2, 3'b010);
      checks++; if (C !== 3'b010) begin failures++; $display("FAIL dup_first got=%b exp=010", C); end
      offer(3'd2, 3'b100);
      checks++; if (reject !== 1'b1) begin failures++; $display("FAIL dup_reject got=%b exp=1", reject); end
      checks++; if (C !== 3'b010) begin failures++; $display("FAIL dup_keep got=%b exp=010", C); end
      offer(3'd3, 3'b001);
      checks++; if (round_valid !== 1'b0) begin failures++; $display("FAIL dup_need4 got=%b exp=0", round_valid); end
      offer(3'd4, 3'b001);
      checks++; if (round_valid !== 1'b1) begin failures++; $display("FAIL dup_complete got=%b exp=1", round_valid); end
   endtask

   task automatic test_backpressure();
      checks++; if (ballot_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", ballot_ready); end
      offer(3'd0, 3'b100);
      checks++; if (reject !== 1'b0) begin failures++; $display("FAIL bp_reject got=%b exp=0", reject); end
      checks++; if (A !== 3'b010 || round_valid !== 1'b1) begin failures++; $display("FAIL bp_frozen A=%b rv=%b exp A=010 rv=1", A, round_valid); end
      ballot_valid = 1'b1; voter_id = 3'd0; ballot = 3'b100;
      round_ack = 1'b1;
      step();
      round_ack = 1'b0;
      checks++; if (A !== 3'b000 || round_cnt !== 8'd2) begin failures++; $display("FAIL bp_ack A=%b cnt=%0d exp A=000 cnt=2", A, round_cnt); end
      step();
      ballot_valid = 1'b0;
      checks++; if (A !== 3'b100 || reject !== 1'b0) begin failures++; $display("FAIL bp_retry A=%b reject=%b exp A=100 reject=0", A, reject); end
   endtask

   task automatic test_abort();
      offer(3'd1, 3'b001);
      offer(3'd2, 3'b010);
      ballot_valid = 1'b1; voter_id = 3'd3; ballot = 3'b100;
      round_abort = 1'b1;
      step();
      round_abort = 1'b0; ballot_valid = 1'b0;
      checks++; if ({A, B, C, D, E} !== 15'd0) begin failures++; $display("FAIL abort_slots got=%h exp=0", {A, B, C, D, E}); end
      checks++; if (round_valid !== 1'b0 || reject !== 1'b0) begin failures++; $display("FAIL abort_flags rv=%b reject=%b exp 0 0", round_valid, reject); end
      checks++; if (round_cnt !== 8'd2) begin failures++; $display("FAIL abort_cnt got=%0d exp=2", round_cnt); end
      // voted was cleared: all five voters can vote again.
      for (int k = 0; k < 5; k++) offer(3'(k), 3'b010);
      checks++; if (round_valid !== 1'b1) begin failures++; $display("FAIL abort_refill got=%b exp=1", round_valid); end
      round_abort = 1'b1; round_ack = 1'b1;
      step();
      round_abort = 1'b0; round_ack = 1'b0;
      checks++; if (round_valid !== 1'b0 || round_cnt !== 8'd2 || A !== 3'b000) begin
         failures++; $display("FAIL abort_present rv=%b cnt=%0d A=%b exp 0 2 000", round_valid, round_cnt, A);
      end
   endtask

   task automatic test_reset_mid_round();
      for (int r = 0; r < 253; r++) run_round();
      checks++; if (round_cnt !== 8'd255) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=255", round_cnt); end
      offer(3'd0, 3'b001);
      offer(3'd1, 3'b010);
      rst = 1'b1;
      step();
      checks++; if ({A, B, C, D, E} !== 15'd0 || round_cnt !== 8'd0) begin failures++; $display("FAIL midrst slots=%h cnt=%0d exp 0 0", {A, B, C, D, E}, round_cnt); end
      checks++; if (round_valid !== 1'b0 || reject !== 1'b0 || ballot_ready !== 1'b0) begin
         failures++; $display("FAIL midrst_flags rv=%b rej=%b rdy=%b exp 0 0 0", round_valid, reject, ballot_ready);
      end
      rst = 1'b0;
      #1;
      checks++; if (ballot_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ballot_ready); end
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 255; r++) run_round();
      checks++; if (round_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", round_cnt); end
      run_round();
      checks++; if (round_cnt !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", round_cnt); end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      ballot_valid = 1'b0;
      ballot       = 3'b000;
      voter_id     = 3'd0;
      round_ack    = 1'b0;
      round_abort  = 1'b0;
      test_reset();
      test_full_round();
      test_illegal();
      test_duplicate();
      test_backpressure();
      test_abort();
      test_reset_mid_round();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
